// File: rtl/fpnew_pkg.sv
// Shared FPnew types used by the opgroup result path.
// Only the exception-flag bundle is needed by the output FIFO.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_opgroup_out_fifo.sv
// Result FIFO behind an opgroup block; decouples arbiter back-pressure.
// Optional sticky flag accumulator: define FPNEW_OUT_FIFO_FFLAGS_EN.
module fpnew_opgroup_out_fifo
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 4,
  parameter type         TagType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [Width-1:0]           result_i,
  input  status_t                    status_i,
  input  logic                       extension_bit_i,
  input  TagType                     tag_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [Width-1:0]           result_o,
  output status_t                    status_o,
  output logic                       extension_bit_o,
  output TagType                     tag_o,
`ifdef FPNEW_OUT_FIFO_FFLAGS_EN
  output status_t                    fflags_o,
  input  logic                       fflags_clr_i,
`endif
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       busy_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } entry_t;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  entry_t          mem_q [Depth];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  entry_t          wr_entry;
  entry_t          head;
  logic            push;
  logic            pop;

  assign in_ready_o  = (count_q != CW'(Depth));
  assign out_valid_o = (count_q != '0);

  // A flush cancels whatever handshake happens in the same cycle.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign wr_entry = '{
    result:  result_i,
    status:  status_i,
    ext_bit: extension_bit_i,
    tag:     tag_i
  };

  assign head = out_valid_o ? mem_q[rd_ptr_q] : '0;

  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext_bit;
  assign tag_o           = head.tag;
  assign usage_o         = count_q;
  assign busy_o          = (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

`ifdef FPNEW_OUT_FIFO_FFLAGS_EN
  logic [4:0] fflags_q;

  // Clear wins over the old value but not over a flag popped this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else if (fflags_clr_i) begin
      fflags_q <= pop ? status_o : '0;
    end else if (pop) begin
      fflags_q <= fflags_q | status_o;
    end
  end

  assign fflags_o = fflags_q;
`endif

endmodule

// File: tb/tb_fpnew_opgroup_out_fifo.sv
// Self-checking bench for fpnew_opgroup_out_fifo.
// Directed table, streaming/flag sequences and a queue-model random run.
module tb_fpnew_opgroup_out_fifo;
  import fpnew_pkg::*;

  localparam int W = 32;
  localparam int D = 4;
  typedef logic [3:0] tag_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result_in;
  logic [4:0]  status_in;
  logic        ext_in;
  tag_t        tag_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_out;
  status_t     status_out;
  logic        ext_out;
  tag_t        tag_out;
  logic [2:0]  usage;
  logic        busy;
  logic        fclr;
  status_t     fflags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpnew_opgroup_out_fifo #(
    .Width  (W),
    .Depth  (D),
    .TagType(tag_t)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .result_i       (result_in),
    .status_i       (status_in),
    .extension_bit_i(ext_in),
    .tag_i          (tag_in),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .result_o       (result_out),
    .status_o       (status_out),
    .extension_bit_o(ext_out),
    .tag_o          (tag_out),
`ifdef FPNEW_OUT_FIFO_FFLAGS_EN
    .fflags_o       (fflags),
    .fflags_clr_i   (fclr),
`endif
    .usage_o        (usage),
    .busy_o         (busy)
  );

`ifndef FPNEW_OUT_FIFO_FFLAGS_EN
  assign fflags = '0;
`endif

  typedef struct {
    logic        iv;
    logic [31:0] r;
    tag_t        tg;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic        eir;
    logic        ebusy;
    logic [31:0] er;
    tag_t        etg;
    logic [2:0]  eu;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  st;
    logic        ex;
    tag_t        tg;
  } ent_t;

  vec_t vecs[12];
  ent_t q[$];
  logic [4:0] fm;
  tag_t got[$];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    result_in = '0;
    status_in = '0;
    ext_in    = 1'b0;
    tag_in    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    fclr      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [31:0] r, input tag_t tg,
    input logic ordy, input logic fl, input logic eov,
    input logic eir, input logic ebusy, input logic [31:0] er,
    input tag_t etg, input logic [2:0] eu);
    vec_t v;
    v = '{iv, r, tg, ordy, fl, eov, eir, ebusy, er, etg, eu};
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    idle();

    // expected values seen just after the edge that ends each row
    vecs[0]  = mk(1, 32'h3F800000, 1, 0, 0, 1, 1, 1, 32'h3F800000, 1, 1);
    vecs[1]  = mk(1, 32'h0000000A, 2, 0, 0, 1, 1, 1, 32'h3F800000, 1, 2);
    vecs[2]  = mk(1, 32'h0000000B, 3, 0, 0, 1, 1, 1, 32'h3F800000, 1, 3);
    vecs[3]  = mk(1, 32'h0000000C, 4, 0, 0, 1, 0, 1, 32'h3F800000, 1, 4);
    vecs[4]  = mk(1, 32'h0000000D, 5, 0, 0, 1, 0, 1, 32'h3F800000, 1, 4);
    vecs[5]  = mk(1, 32'h0000000D, 5, 1, 0, 1, 1, 1, 32'h0000000A, 2, 3);
    vecs[6]  = mk(1, 32'h0000000D, 5, 0, 0, 1, 0, 1, 32'h0000000A, 2, 4);
    vecs[7]  = mk(0, 32'h00000000, 0, 1, 0, 1, 1, 1, 32'h0000000B, 3, 3);
    vecs[8]  = mk(1, 32'h0000000E, 6, 1, 1, 0, 1, 0, 32'h00000000, 0, 0);
    vecs[9]  = mk(0, 32'h00000000, 0, 1, 0, 0, 1, 0, 32'h00000000, 0, 0);
    vecs[10] = mk(1, 32'h0000000F, 7, 1, 0, 1, 1, 1, 32'h0000000F, 7, 1);
    vecs[11] = mk(0, 32'h00000000, 0, 1, 0, 0, 1, 0, 32'h00000000, 0, 0);

    do_reset();
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_usage", usage, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", result_out, 0);
    chk("rst_ff", fflags, 0);

    for (int i = 0; i < 12; i++) begin
      in_valid  = vecs[i].iv;
      result_in = vecs[i].r;
      tag_in    = vecs[i].tg;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      tick();
      chk($sformatf("v%0d_ov", i), out_valid, vecs[i].eov);
      chk($sformatf("v%0d_ir", i), in_ready, vecs[i].eir);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].ebusy);
      chk($sformatf("v%0d_res", i), result_out, vecs[i].er);
      chk($sformatf("v%0d_tag", i), tag_out, vecs[i].etg);
      chk($sformatf("v%0d_use", i), usage, vecs[i].eu);
    end
    idle();

    // stream 10 tags with toggling ready; pointers wrap twice
    begin
      int sent;
      int cyc;
      sent = 0;
      got.delete();
      cyc = 0;
      while (got.size() < 10 && cyc < 80) begin
        in_valid  = (sent < 10);
        result_in = 32'(sent) + 32'h100;
        tag_in    = tag_t'(sent);
        out_ready = cyc[0];
        #1;
        if (out_valid && out_ready) got.push_back(tag_out);
        if (in_valid && in_ready) sent++;
        tick();
        cyc++;
      end
      idle();
      chk("stream_cnt", 64'(got.size()), 10);
      for (int i = 0; i < got.size(); i++)
        chk($sformatf("stream_tag%0d", i), got[i], i);
      chk("stream_empty", usage, 0);
    end

`ifdef FPNEW_OUT_FIFO_FFLAGS_EN
    do_reset();
    in_valid = 1'b1;
    status_in = 5'b00001; tick();
    status_in = 5'b10000; tick();
    status_in = 5'b00100; tick();
    in_valid = 1'b0;
    chk("ff_hold", fflags, 0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("ff_acc", fflags, 5'b10001);
    out_ready = 1'b1;
    fclr = 1'b1;
    tick();
    idle();
    chk("ff_clr_pop", fflags, 5'b00100);
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    chk("ff_clr", fflags, 0);
`endif

    // reset mid-transfer wins over flush and drops the contents
    in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("midrst_use", usage, 0);
    chk("midrst_ov", out_valid, 0);

    q.delete();
    fm = '0;
    for (int c = 0; c < 400; c++) begin
      logic pu;
      logic po;
      in_valid  = ($urandom_range(0, 3) != 0);
      result_in = $urandom;
      status_in = 5'($urandom);
      ext_in    = 1'($urandom);
      tag_in    = tag_t'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
`ifdef FPNEW_OUT_FIFO_FFLAGS_EN
      fclr      = ($urandom_range(0, 9) == 0);
`endif
      #1;
      chk("rnd_ov", out_valid, q.size() != 0);
      chk("rnd_ir", in_ready, q.size() != D);
      chk("rnd_use", usage, 64'(q.size()));
      chk("rnd_busy", busy, q.size() != 0);
`ifdef FPNEW_OUT_FIFO_FFLAGS_EN
      chk("rnd_ff", fflags, fm);
`endif
      if (q.size() != 0) begin
        chk("rnd_res", result_out, q[0].r);
        chk("rnd_st", status_out, q[0].st);
        chk("rnd_ex", ext_out, q[0].ex);
        chk("rnd_tag", tag_out, q[0].tg);
      end else begin
        chk("rnd_res0", {result_out, status_out, ext_out, tag_out}, 0);
      end
      pu = in_valid && q.size() != D && !flush;
      po = out_ready && q.size() != 0 && !flush;
      if (fclr) fm = po ? q[0].st : 5'b0;
      else if (po) fm = fm | q[0].st;
      if (flush) q.delete();
      else begin
        if (po) void'(q.pop_front());
        if (pu) q.push_back('{result_in, status_in, ext_in, tag_in});
      end
      tick();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
